// File: rtl/ysyx_25020037_axi_sram.sv
// AXI4 responder backed by a word-organised SRAM: one transaction at a time,
// INCR/FIXED bursts, byte strobes, programmable latency, DECERR outside the window.
module ysyx_25020037_axi_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 2,
  parameter int          WR_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, R_LAT, R_BEAT, W_DATA, W_LAT, B_RESP} state_t;
  localparam state_t W_END = (WR_LATENCY == 0) ? B_RESP : W_LAT;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [3:0]  id_q;
  logic [7:0]  len_q, beat_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  lat_q;
  logic        decerr_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Wrapping subtraction pushes addresses below BASE_ADDR far past SPAN.
  function automatic logic in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < SPAN;
  endfunction

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] s,
                                            input logic [1:0] b);
    return (b == 2'b01) ? a + (32'd1 << s) : a;
  endfunction

  logic unused_awlen;
  assign unused_awlen = ^awlen;

  // The first W beat may ride along with AW, so it uses the live AW fields.
  logic [31:0]   w_addr;
  logic [1:0]    w_burst;
  logic [AW-1:0] w_idx, r_idx;
  logic          mem_we;
  assign w_addr  = (state_q == IDLE) ? awaddr : addr_q;
  assign w_burst = (state_q == IDLE) ? awburst : burst_q;
  assign w_idx   = AW'((w_addr - BASE_ADDR) >> 2);
  assign r_idx   = AW'((addr_q - BASE_ADDR) >> 2);
  assign mem_we  = wvalid && wready && (state_q == W_DATA || awvalid) &&
                   !w_burst[1] && in_win(w_addr);

  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      lat_q    <= '0;
      decerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          lat_q  <= '0;
          beat_q <= '0;
          if (arvalid) begin
            addr_q  <= araddr;
            id_q    <= arid;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
          end else if (awvalid) begin
            id_q     <= awid;
            size_q   <= awsize;
            burst_q  <= awburst;
            addr_q   <= wvalid ? step_addr(awaddr, awsize, awburst) : awaddr;
            decerr_q <= wvalid && !awburst[1] && !in_win(awaddr);
          end
        end
        R_LAT:  lat_q <= lat_q + 4'd1;
        R_BEAT: if (rready && !rlast) begin
          beat_q <= beat_q + 8'd1;
          addr_q <= step_addr(addr_q, size_q, burst_q);
        end
        W_DATA: if (wvalid) begin
          addr_q   <= step_addr(addr_q, size_q, burst_q);
          decerr_q <= decerr_q || (!burst_q[1] && !in_win(addr_q));
        end
        W_LAT:  lat_q <= lat_q + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = '0;
    rlast   = 1'b0;
    rid     = '0;
    bvalid  = 1'b0;
    bresp   = '0;
    bid     = '0;
    unique case (state_q)
      IDLE: begin
        arready = 1'b1;
        awready = !arvalid;
        wready  = !arvalid;
        if (arvalid)      state_d = (RD_LATENCY == 0) ? R_BEAT : R_LAT;
        else if (awvalid) state_d = (wvalid && wlast) ? W_END : W_DATA;
      end
      R_LAT: if (lat_q == 4'(RD_LATENCY - 1)) state_d = R_BEAT;
      R_BEAT: begin
        rvalid = 1'b1;
        rid    = id_q;
        rlast  = (beat_q == len_q);
        if (!burst_q[1] && in_win(addr_q)) rdata = mem[r_idx];
        rresp  = burst_q[1] ? 2'b10 : (in_win(addr_q) ? 2'b00 : 2'b11);
        if (rready && rlast) state_d = IDLE;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) state_d = W_END;
      end
      W_LAT: if (lat_q == 4'(WR_LATENCY - 1)) state_d = B_RESP;
      B_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = burst_q[1] ? 2'b10 : (decerr_q ? 2'b11 : 2'b00);
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ysyx_25020037_axi_sram.sv
// Bench for the AXI SRAM responder: vector table of single-beat accesses plus
// hand-written burst, stall, arbitration and reset sequences, scoreboarded.
module tb_ysyx_25020037_axi_sram;
  logic        clk = 1'b0, rst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  ysyx_25020037_axi_sram dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  int cyc = 0, nvec = 0, nerr = 0;
  initial forever begin @(posedge clk); cyc++; end

  typedef struct {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rexp_t;
  typedef struct {logic [1:0] resp; logic [3:0] id;} bexp_t;
  typedef struct {
    bit wr; logic [31:0] addr; logic [1:0] burst; logic [31:0] wdata; logic [3:0] wstrb;
    logic [31:0] edata; logic [1:0] eresp;
  } vec_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] wbuf [16];
  logic [3:0]  wstb [16];
  vec_t        vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Response monitor: pops the scoreboard on every R/B handshake.
  initial begin : mon
    rexp_t re;
    bexp_t be;
    forever begin
      @(negedge clk);
      if (!rst && rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
        else begin
          re = rq.pop_front();
          chk("rdata", rdata, re.data);
          chk("rresp", 32'(rresp), 32'(re.resp));
          chk("rlast", 32'(rlast), 32'(re.last));
          chk("rid", 32'(rid), 32'(re.id));
        end
      end
      if (!rst && bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
        else begin
          be = bq.pop_front();
          chk("bresp", 32'(bresp), 32'(be.resp));
          chk("bid", 32'(bid), 32'(be.id));
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [3:0] id, input logic [1:0] bt,
                           input int n, output int t_last);
    int k = 0, g = 0;
    logic haw, hw;
    awvalid = 1; awaddr = a; awid = id; awlen = 8'(n - 1); awsize = 3'd2; awburst = bt;
    wvalid = 1; wdata = wbuf[0]; wstrb = wstb[0]; wlast = (n == 1);
    t_last = -100;
    while (k < n && g < 100) begin
      #1;
      haw = awvalid && awready;
      hw  = wvalid && wready;
      if (hw) t_last = cyc;
      step();
      if (haw) awvalid = 0;
      if (hw) begin
        k++;
        if (k < n) begin wdata = wbuf[k]; wstrb = wstb[k]; wlast = (k == n - 1); end
        else begin wvalid = 0; wlast = 0; end
      end
      g++;
    end
    awvalid = 0; wvalid = 0;
    if (k < n) chk("w_timeout", 32'(k), 32'(n));
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [3:0] id, input logic [1:0] bt,
                          input logic [7:0] len, output int t_ar);
    int g = 0;
    logic done = 0;
    arvalid = 1; araddr = a; arid = id; arlen = len; arsize = 3'd2; arburst = bt;
    t_ar = -100;
    while (!done && g < 50) begin
      #1;
      done = arready;
      if (done) t_ar = cyc;
      step();
      g++;
    end
    arvalid = 0;
    if (!done) chk("ar_timeout", 32'd0, 32'd1);
  endtask

  // Waits until the scoreboard queue drains; t = first cycle the valid was seen.
  task automatic wait_resp(input bit rd, output int t);
    int g = 0;
    t = -1;
    while (g < 200 && (rd ? rq.size() : bq.size()) != 0) begin
      #1;
      if (t < 0 && (rd ? rvalid : bvalid)) t = cyc;
      step();
      g++;
    end
    if ((rd ? rq.size() : bq.size()) != 0) chk(rd ? "r_timeout" : "b_timeout", 32'd1, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, g;
    logic saw_aw, done;
    vt[0]  = '{1'b1, 32'h8000_0010, 2'b01, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
    vt[1]  = '{1'b0, 32'h8000_0010, 2'b01, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
    vt[2]  = '{1'b1, 32'h8000_0020, 2'b01, 32'h11223344, 4'hF, 32'h0, 2'b00};
    vt[3]  = '{1'b1, 32'h8000_0020, 2'b01, 32'h0000AA00, 4'b0010, 32'h0, 2'b00};
    vt[4]  = '{1'b0, 32'h8000_0020, 2'b01, 32'h0, 4'h0, 32'h1122AA44, 2'b00};
    vt[5]  = '{1'b0, 32'h9000_0000, 2'b01, 32'h0, 4'h0, 32'h0, 2'b11};
    vt[6]  = '{1'b1, 32'h8000_0FFC, 2'b01, 32'h0000_0055, 4'hF, 32'h0, 2'b00};
    vt[7]  = '{1'b0, 32'h8000_0FFC, 2'b01, 32'h0, 4'h0, 32'h0000_0055, 2'b00};
    vt[8]  = '{1'b0, 32'h8000_1000, 2'b01, 32'h0, 4'h0, 32'h0, 2'b11};
    vt[9]  = '{1'b1, 32'h7FFF_FFFC, 2'b01, 32'hCAFEF00D, 4'hF, 32'h0, 2'b11};
    vt[10] = '{1'b0, 32'h7FFF_FFFC, 2'b01, 32'h0, 4'h0, 32'h0, 2'b11};
    vt[11] = '{1'b0, 32'h8000_0FFC, 2'b01, 32'h0, 4'h0, 32'h0000_0055, 2'b00};
    vt[12] = '{1'b0, 32'h8000_0010, 2'b10, 32'h0, 4'h0, 32'h0, 2'b10};
    vt[13] = '{1'b1, 32'h8000_0010, 2'b10, 32'h0, 4'hF, 32'h0, 2'b10};
    vt[14] = '{1'b0, 32'h8000_0010, 2'b01, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00};
    vt[15] = '{1'b1, 32'h8000_0020, 2'b01, 32'hFF0000EE, 4'b1001, 32'h0, 2'b00};

    rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wdata = 0; wstrb = 0; wlast = 0;
    araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    repeat (3) step();
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_bresp_bid", 32'({bresp, bid}), 32'd0);
    chk("rst_rresp_rid", 32'({rresp, rid}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 0;
    step();
    chk("idle_ready", 32'({arready, awready, wready}), 32'b111);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) begin
        wbuf[0] = vt[i].wdata; wstb[0] = vt[i].wstrb;
        bq.push_back('{vt[i].eresp, 4'(i)});
        axi_write(vt[i].addr, 4'(i), vt[i].burst, 1, t0);
        wait_resp(1'b0, t1);
        chk($sformatf("v%0d_wr_lat", i), 32'(t1), 32'(t0 + 2));
      end else begin
        rq.push_back('{vt[i].edata, vt[i].eresp, 1'b1, 4'(i)});
        axi_read(vt[i].addr, 4'(i), vt[i].burst, 8'd0, t0);
        wait_resp(1'b1, t1);
        chk($sformatf("v%0d_rd_lat", i), 32'(t1), 32'(t0 + 3));
      end
    end
    // v15 readback: bytes 3 and 0 replaced
    rq.push_back('{32'hFF22AAEE, 2'b00, 1'b1, 4'h9});
    axi_read(32'h8000_0020, 4'h9, 2'b01, 8'd0, t0);
    wait_resp(1'b1, t1);

    // Four-beat INCR preload, then an INCR read with a two-cycle stall on beat 1.
    for (int k = 0; k < 4; k++) begin wbuf[k] = 32'(k + 1); wstb[k] = 4'hF; end
    bq.push_back('{2'b00, 4'h1});
    axi_write(32'h8000_0000, 4'h1, 2'b01, 4, t0);
    wait_resp(1'b0, t1);
    chk("burst_wr_lat", 32'(t1), 32'(t0 + 2));
    for (int k = 0; k < 4; k++) rq.push_back('{32'(k + 1), 2'b00, (k == 3), 4'h2});
    rready = 0;
    axi_read(32'h8000_0000, 4'h2, 2'b01, 8'd3, t0);
    g = 0;
    while (!rvalid && g < 20) begin step(); g++; end
    chk("stall_first_lat", 32'(cyc), 32'(t0 + 3));
    for (int s = 0; s < 2; s++) begin
      chk("stall_rvalid", 32'(rvalid), 32'd1);
      chk("stall_rdata", rdata, 32'd1);
      chk("stall_rlast", 32'(rlast), 32'd0);
      step();
    end
    rready = 1;
    wait_resp(1'b1, t1);

    // INCR burst straddling the window end: OKAY then DECERR.
    rq.push_back('{32'h55, 2'b00, 1'b0, 4'h3});
    rq.push_back('{32'h0, 2'b11, 1'b1, 4'h3});
    axi_read(32'h8000_0FFC, 4'h3, 2'b01, 8'd1, t0);
    wait_resp(1'b1, t1);

    // AR and AW together: read first, AW held off until the read finishes.
    rq.push_back('{32'h2, 2'b00, 1'b1, 4'h4});
    bq.push_back('{2'b00, 4'h5});
    arvalid = 1; araddr = 32'h8000_0004; arid = 4'h4; arlen = 0; arsize = 3'd2; arburst = 2'b01;
    awvalid = 1; awaddr = 32'h8000_0008; awid = 4'h5; awlen = 0; awsize = 3'd2; awburst = 2'b01;
    wvalid = 1; wdata = 32'h77; wstrb = 4'hF; wlast = 1;
    #1;
    chk("arb_arready", 32'(arready), 32'd1);
    chk("arb_awready", 32'({awready, wready}), 32'd0);
    step();
    arvalid = 0;
    saw_aw = 0; g = 0;
    while (rq.size() != 0 && g < 30) begin
      #1;
      if (awready) saw_aw = 1;
      step(); g++;
    end
    chk("arb_aw_held", 32'(saw_aw), 32'd0);
    chk("arb_rd_done", 32'(rq.size()), 32'd0);
    done = 0; g = 0; t0 = -100;
    while (!done && g < 10) begin
      #1;
      done = awready && wready;
      if (done) t0 = cyc;
      step(); g++;
    end
    awvalid = 0; wvalid = 0; wlast = 0;
    chk("arb_aw_taken", 32'(done), 32'd1);
    wait_resp(1'b0, t1);
    chk("arb_wr_lat", 32'(t1), 32'(t0 + 2));
    rq.push_back('{32'h77, 2'b00, 1'b1, 4'h5});
    axi_read(32'h8000_0008, 4'h5, 2'b01, 8'd0, t0);
    wait_resp(1'b1, t1);

    // Reset pulse while beat 2 of a four-beat read is on the bus.
    for (int k = 0; k < 4; k++) rq.push_back('{32'(k + 1), 2'b00, (k == 3), 4'h6});
    axi_read(32'h8000_0000, 4'h6, 2'b01, 8'd3, t0);
    g = 0;
    while (rq.size() > 3 && g < 20) begin step(); g++; end
    chk("rst_mid_beat2", rdata, 32'd2);
    rst = 1;
    step();
    rst = 0;
    rq.delete();
    #1;
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    chk("rst_mid_arready", 32'(arready), 32'd1);
    step();
    rq.push_back('{32'h4, 2'b00, 1'b1, 4'h7});
    axi_read(32'h8000_000C, 4'h7, 2'b01, 8'd0, t0);
    wait_resp(1'b1, t1);
    chk("rst_after_rd_lat", 32'(t1), 32'(t0 + 3));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
